// File: rtl/set_assoc_cache_pkg.sv
// Shared types for the set-associative cache: request ops, controller
// states and per-line status.
package set_assoc_cache_pkg;

  typedef enum logic [1:0] {
    Op_INVALID = 2'd0,
    Op_READ    = 2'd1,
    Op_WRITE   = 2'd2
  } Op;

  typedef enum logic [1:0] {
    State_READY     = 2'd0,
    State_WRITEBACK = 2'd1,
    State_FILL      = 2'd2
  } State;

  typedef enum logic [1:0] {
    Status_INVALID = 2'd0,
    Status_CLEAN   = 2'd1,
    Status_DIRTY   = 2'd2
  } Status;

  // Only one- and two-way organisations are supported (one LRU bit per set).
  localparam int unsigned MAX_WAYS = 32'd2;

  // A line takes part in tag compare only when it holds data.
  function automatic logic line_is_valid(input Status s);
    return (s != Status_INVALID);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Core request/response and memory request/response bundle of the cache.
// slave = cache view, master = core/memory environment view.
interface set_assoc_cache_if #(
  parameter int unsigned ADDR_WIDTH = 32'd6,
  parameter int unsigned DATA_WIDTH = 32'd8
);
  import set_assoc_cache_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  Op                     req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  Op                     mem_req_op;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data,
    output mem_req_valid, mem_req_op, mem_req_addr, mem_req_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_req_valid, mem_req_op, mem_req_addr, mem_req_data
  );

endinterface

// File: rtl/set_assoc_cache_way.sv
// One cache way: status, tag and data arrays indexed by set.
// Combinational lookup port, synchronous single write port, and a
// synchronous reset that invalidates every line at once.
module cache_way
  import set_assoc_cache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH   = 32'd3,
  parameter int unsigned INDEX_WIDTH = 32'd3,
  parameter int unsigned DATA_WIDTH  = 32'd8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  input  logic [TAG_WIDTH-1:0]   rd_tag_i,
  output logic                   hit_o,
  output Status                  status_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] wr_index_i,
  input  Status                  wr_status_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i
);

  localparam int unsigned SETS = 32'd1 << INDEX_WIDTH;

  Status                 status_q [SETS];
  logic [TAG_WIDTH-1:0]  tag_q    [SETS];
  logic [DATA_WIDTH-1:0] data_q   [SETS];

  assign status_o = status_q[rd_index_i];
  assign tag_o    = tag_q[rd_index_i];
  assign data_o   = data_q[rd_index_i];
  assign hit_o    = line_is_valid(status_o) && (tag_o == rd_tag_i);

  // Line storage: clear all sets on reset, otherwise write one set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        status_q[s] <= Status_INVALID;
        tag_q[s]    <= '0;
        data_q[s]   <= '0;
      end
    end else if (we_i) begin
      status_q[wr_index_i] <= wr_status_i;
      tag_q[wr_index_i]    <= wr_tag_i;
      data_q[wr_index_i]   <= wr_data_i;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate cache with 1 or 2 ways and true-LRU
// replacement. Misses write back a dirty victim, then fill the line over
// a single memory request/response channel.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32'd6,
  parameter int unsigned INDEX_WIDTH = 32'd3,
  parameter int unsigned DATA_WIDTH  = 32'd8,
  parameter int unsigned WAYS        = 32'd2
) (
  input logic             clk,
  input logic             rst,
  set_assoc_cache_if.slave bus
);

  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int unsigned SETS      = 32'd1 << INDEX_WIDTH;

  typedef logic [0:0] way_t;

  // Lookup side
  logic [INDEX_WIDTH-1:0] req_idx_s;
  logic [TAG_WIDTH-1:0]   req_tag_s;
  logic [WAYS-1:0]        hit_s;
  Status                  status_s [WAYS];
  logic [TAG_WIDTH-1:0]   tag_s    [WAYS];
  logic [DATA_WIDTH-1:0]  data_s   [WAYS];
  logic                   hit_any_s;
  way_t                   hit_way_s;
  logic                   inv_found_s;
  way_t                   inv_way_s;
  way_t                   victim_s;

  // Shared write port into the ways
  logic [WAYS-1:0]        we_s;
  logic [INDEX_WIDTH-1:0] wr_index_s;
  Status                  wr_status_s;
  logic [TAG_WIDTH-1:0]   wr_tag_s;
  logic [DATA_WIDTH-1:0]  wr_data_s;

  // Controller state
  State                  state_q, state_d;
  logic [SETS-1:0]       lru_q, lru_d;
  Op                     req_op_q, req_op_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  way_t                  victim_q, victim_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  Op                     mem_req_op_q, mem_req_op_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_WIDTH-1:0] mem_req_data_q, mem_req_data_d;

  logic [INDEX_WIDTH-1:0] pend_idx_s;
  logic [TAG_WIDTH-1:0]   pend_tag_s;

  assign req_idx_s  = bus.req_addr[INDEX_WIDTH-1:0];
  assign req_tag_s  = bus.req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign pend_idx_s = req_addr_q[INDEX_WIDTH-1:0];
  assign pend_tag_s = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];

  for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
    cache_way #(
      .TAG_WIDTH  (TAG_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_index_i (req_idx_s),
      .rd_tag_i   (req_tag_s),
      .hit_o      (hit_s[w]),
      .status_o   (status_s[w]),
      .tag_o      (tag_s[w]),
      .data_o     (data_s[w]),
      .we_i       (we_s[w]),
      .wr_index_i (wr_index_s),
      .wr_status_i(wr_status_s),
      .wr_tag_i   (wr_tag_s),
      .wr_data_i  (wr_data_s)
    );
  end

  // Hit way and victim: lowest-numbered invalid way first, else the LRU way.
  always_comb begin
    hit_any_s   = 1'b0;
    hit_way_s   = 1'b0;
    inv_found_s = 1'b0;
    inv_way_s   = 1'b0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      hit_any_s   = hit_any_s | hit_s[w];
      hit_way_s   = hit_s[w] ? way_t'(w) : hit_way_s;
      inv_found_s = inv_found_s | (status_s[w] == Status_INVALID);
      inv_way_s   = (status_s[w] == Status_INVALID) ? way_t'(w) : inv_way_s;
    end
    victim_s = inv_found_s ? inv_way_s
             : ((WAYS == 32'd1) ? 1'b0 : lru_q[req_idx_s]);
  end

  // Next-state, way write port and output register values.
  always_comb begin
    state_d         = state_q;
    lru_d           = lru_q;
    req_op_d        = req_op_q;
    req_addr_d      = req_addr_q;
    req_data_d      = req_data_q;
    victim_d        = victim_q;
    req_ready_d     = req_ready_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_op_d    = mem_req_op_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    we_s            = '0;
    wr_index_s      = req_idx_s;
    wr_status_s     = Status_DIRTY;
    wr_tag_s        = req_tag_s;
    wr_data_s       = bus.req_data;

    case (state_q)
      State_READY: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q &&
            ((bus.req_op == Op_READ) || (bus.req_op == Op_WRITE))) begin
          if (hit_any_s) begin
            rsp_valid_d       = 1'b1;
            lru_d[req_idx_s]  = ~hit_way_s;
            if (bus.req_op == Op_WRITE) begin
              we_s[hit_way_s] = 1'b1;
              rsp_data_d      = bus.req_data;
            end else begin
              rsp_data_d      = data_s[hit_way_s];
            end
          end else begin
            req_op_d        = bus.req_op;
            req_addr_d      = bus.req_addr;
            req_data_d      = bus.req_data;
            victim_d        = victim_s;
            req_ready_d     = 1'b0;
            mem_req_valid_d = 1'b1;
            mem_req_data_d  = data_s[victim_s];
            if (status_s[victim_s] == Status_DIRTY) begin
              state_d        = State_WRITEBACK;
              mem_req_op_d   = Op_WRITE;
              mem_req_addr_d = {tag_s[victim_s], req_idx_s};
            end else begin
              state_d        = State_FILL;
              mem_req_op_d   = Op_READ;
              mem_req_addr_d = bus.req_addr;
            end
          end
        end else begin
          // Idle cycle or Op_INVALID request: accepted with no effect.
          state_d = State_READY;
        end
      end

      State_WRITEBACK: begin
        req_ready_d = 1'b0;
        if (mem_req_valid_q && bus.mem_req_ready) begin
          state_d         = State_FILL;
          mem_req_valid_d = 1'b1;
          mem_req_op_d    = Op_READ;
          mem_req_addr_d  = req_addr_q;
        end else begin
          state_d = State_WRITEBACK;
        end
      end

      State_FILL: begin
        req_ready_d = 1'b0;
        if (mem_req_valid_q) begin
          // Fill request still outstanding; response is not expected yet.
          mem_req_valid_d = !bus.mem_req_ready;
        end else if (bus.mem_rsp_valid) begin
          we_s[victim_q]    = 1'b1;
          wr_index_s        = pend_idx_s;
          wr_tag_s          = pend_tag_s;
          lru_d[pend_idx_s] = ~victim_q;
          rsp_valid_d       = 1'b1;
          req_ready_d       = 1'b1;
          state_d           = State_READY;
          if (req_op_q == Op_WRITE) begin
            wr_status_s = Status_DIRTY;
            wr_data_s   = req_data_q;
            rsp_data_d  = req_data_q;
          end else begin
            wr_status_s = Status_CLEAN;
            wr_data_s   = bus.mem_rsp_data;
            rsp_data_d  = bus.mem_rsp_data;
          end
        end else begin
          state_d = State_FILL;
        end
      end

      default: begin
        state_d         = State_READY;
        req_ready_d     = 1'b1;
        mem_req_valid_d = 1'b0;
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= State_READY;
      lru_q           <= '0;
      req_op_q        <= Op_INVALID;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      victim_q        <= 1'b0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_op_q    <= Op_INVALID;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      lru_q           <= lru_d;
      req_op_q        <= req_op_d;
      req_addr_q      <= req_addr_d;
      req_data_q      <= req_data_d;
      victim_q        <= victim_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_op_q    <= mem_req_op_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_op    = mem_req_op_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_data  = mem_req_data_q;

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised write-back, write-allocate cache with 1 or 2 ways per set, true-LRU replacement, and a valid/ready core request port. It sits between the core request stream and the memory model and issues writebacks and line fills over a single memory request/response channel. It reuses the shared `Op`, `State` and `Status` enums and extends the original single-way, fixed-width cache to configurable address, index, data width and associativity.

## Interface
- `ADDR_WIDTH`, 6, address bits; tag width = `ADDR_WIDTH - INDEX_WIDTH`
- `INDEX_WIDTH`, 3, set index bits; 2**`INDEX_WIDTH` sets
- `DATA_WIDTH`, 8, bits per line (one word per line)
- `WAYS`, 2, associativity; legal values are 1 and 2 only
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  cache can accept a request
- `req_op`  in  `Op`  `Op_READ` or `Op_WRITE`
- `req_addr`  in  `ADDR_WIDTH`  address as {tag, index}
- `req_data`  in  `DATA_WIDTH`  write data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_data`  out  `DATA_WIDTH`  read data, or the written data for writes
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_op`  out  `Op`  `Op_WRITE` for writeback, `Op_READ` for fill
- `mem_req_addr`  out  `ADDR_WIDTH`  line address
- `mem_req_data`  out  `DATA_WIDTH`  writeback data
- `mem_rsp_valid`  in  1  fill data valid
- `mem_rsp_data`  in  `DATA_WIDTH`  fill data

## Operation
- State machine: `State_READY`, `State_WRITEBACK`, `State_FILL`.
- Reset:
  - All lines go to `Status_INVALID` in one cycle; all LRU bits go to 0; state goes to READY.
  - Outputs: `rsp_valid`=0, `mem_req_valid`=0, `req_ready`=1. `rsp_data`, `mem_req_addr` and `mem_req_data` go to 0. `mem_req_op` goes to `Op_INVALID`.
- READY:
  - `req_ready`=1.
  - On acceptance the cache looks up the set and compares tags against all non-INVALID ways.
  - Read hit: respond with the line data.
  - Write hit: replace the data, set the line DIRTY, respond with `req_data`.
  - Any hit marks the hit way as most-recently-used.
  - `Op_INVALID` requests are accepted and dropped: no response, no state change.
- Miss, victim selection:
  - The lowest-numbered INVALID way is chosen first; otherwise the LRU way.
  - The request (op, address, data) and the victim are latched.
  - A DIRTY victim goes to WRITEBACK; otherwise the cache goes to FILL.
- WRITEBACK:
  - Drives `mem_req_valid`=1, `Op_WRITE`, victim address {victim tag, index}, and victim data.
  - On `mem_req_valid && mem_req_ready` the cache goes to FILL.
- FILL:
  - Drives `Op_READ` at the request address until it is accepted, then waits for `mem_rsp_valid`.
  - Installs the line into the victim way with the request tag.
  - Read: line CLEAN with `mem_rsp_data`; the response carries `mem_rsp_data`.
  - Write: line DIRTY with `req_data`; the response carries `req_data`.
  - Marks the victim way MRU and returns to READY.
- `WAYS`=1: direct-mapped; LRU state exists but is unused.
- `mem_rsp_valid` is ignored outside FILL-after-acceptance.

## Timing
- Handshakes:
  - A transfer happens on the rising edge with valid && ready.
  - Valid, address and data hold stable until ready.
  - `mem_req_valid` never drops without acceptance, except on reset.
- Hit: `rsp_valid` is asserted the cycle after acceptance. `req_ready` stays high, so back-to-back hits sustain one per cycle.
- Miss: `req_ready`=0 from the cycle after acceptance until the cycle after the response.
- `mem_req_valid` rises the cycle after the miss is accepted.
- Fill response: `rsp_valid` is asserted the cycle after `mem_rsp_valid`; the state is READY in the same cycle.
- WRITEBACK to FILL: the fill request is driven the cycle after writeback acceptance.
- Same-cycle `mem_rsp_valid` and request acceptance in FILL is illegal; the memory model never does it.
- Reset mid-miss: the next cycle is READY with all lines INVALID. The pending request is dropped with no response. Late `mem_rsp_valid` is ignored.

## Structure
- The shared package keeps `Op`, `State` and `Status` unchanged.
- The old fixed `Line` struct is not reused. Per-way status, tag and data arrays are sized from parameters inside the block.
- One sub-module, `cache_way`, holds one way's status, tag and data arrays. It provides a combinational hit/read port and a synchronous write/invalidate-all port, and is instanced `WAYS` times.
- The FSM, victim selection and LRU bits (one per set) live in `set_assoc_cache`.

## Test plan
- Cold read and re-read:
  - Stimulus: reset, read 0x05; memory returns 0xA5.
  - Required: one `mem_req` `Op_READ` at 0x05, then `rsp_data`=0xA5.
  - Stimulus: read 0x05 again.
  - Required: `rsp_valid` the next cycle, no memory traffic.
- Eviction with writeback (`WAYS`=2):
  - Stimulus: write 0x05 with 0x3C.
  - Required: hit, line DIRTY.
  - Stimulus: read 0x0D.
  - Required: fill into way 1, no writeback.
  - Stimulus: read 0x15.
  - Required: writeback `Op_WRITE` 0x05 data 0x3C, then `Op_READ` 0x15.
- Write miss:
  - Stimulus: write 0x22 with 0x77; memory returns 0x11.
  - Required: `rsp_data`=0x77, line DIRTY.
  - Stimulus: a later eviction of that line.
  - Required: the writeback carries 0x77.
- Backpressure:
  - Stimulus: `mem_req_ready` held low for 5 cycles in WRITEBACK.
  - Required: `mem_req_valid`, address and data stable; `req_ready`=0 throughout.
- Reset during FILL:
  - Required: next cycle `req_ready`=1, `mem_req_valid`=0, no `rsp_valid`.
  - Required: a late `mem_rsp_valid` is ignored.
  - Required: a read of 0x05 misses.
- Invalid op:
  - Stimulus: an `Op_INVALID` request.
  - Required: accepted, no `rsp_valid`, no memory traffic, LRU unchanged.
